// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared constants, types and PC helpers for the instruction fetch sequencer.
package imem_pkg;

    localparam logic [31:0] START_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 2048;

    typedef enum logic {RUN, HALT} fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [10:0] pc_index(input logic [31:0] pc, input logic [31:0] base);
        return 11'((pc - base) >> 2);
    endfunction

    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] base,
                                      input int words);
        logic [31:0] lim;
        lim = base + (32'(words) << 2);
        return (pc[1:0] == 2'b00) && (pc >= base) && (pc < lim);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_buf.sv
// Shift-register FIFO of fetched {pc, instr}; entry 0 is always the head.
module fetch_buf
    import imem_pkg::*;
#(
    parameter int          DEPTH  = 3,
    parameter logic [31:0] RST_PC = START_PC,
    localparam int         CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [31:0]   push_pc_i,
    input  logic [31:0]   push_instr_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output logic [31:0]   head_pc_o,
    output logic [31:0]   head_instr_o
);

    fetch_entry_t  ent_q [DEPTH];
    fetch_entry_t  ent_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d, wr_idx;

    always_comb begin
        ent_d  = ent_q;
        wr_idx = cnt_q - CW'(pop_i);
        if (pop_i) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i + 1];
        end
        // A push lands just behind the last surviving entry after any pop.
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_idx == CW'(i))) ent_d[i] = '{pc: push_pc_i, instr: push_instr_i};
        end
        cnt_d = flush_i ? '0 : (cnt_q + CW'(push_i) - CW'(pop_i));
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
        if (reset) begin
            cnt_q    <= '0;
            ent_q[0] <= '{pc: RST_PC, instr: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o      = cnt_q;
    assign head_pc_o    = ent_q[0].pc;
    assign head_instr_o = ent_q[0].instr;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues instruction memory reads, buffers the
// returned words for decode and traps bad PCs into a sticky halted fault state.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          BUF_DEPTH = 3,
    parameter logic [31:0] START_PC  = imem_pkg::START_PC,
    parameter int          IM_WORDS  = imem_pkg::IM_WORDS,
    localparam int         CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_en,
    output logic [10:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    fetch_state_e  state_q;
    logic          fault_q;
    logic [31:0]   pc_q;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    logic [CW-1:0] occ;
    logic          room, issue_opp, issue, redirect_ok, redirect_bad, push, pop;

    // One slot is always reserved for the read in flight, so the buffer cannot overflow.
    assign room         = (int'(occ) + int'(inflight_q)) < BUF_DEPTH;
    assign issue_opp    = (state_q == RUN) && !redirect_valid && room && !reset;
    assign issue        = issue_opp && pc_legal(pc_q, START_PC, IM_WORDS);
    assign redirect_ok  = redirect_valid && pc_legal(redirect_pc, START_PC, IM_WORDS);
    assign redirect_bad = redirect_valid && !redirect_ok;

    // A trapping redirect leaves the buffer and the outstanding read alone so they drain.
    assign push = inflight_q && !redirect_ok;
    assign pop  = out_valid && out_ready;

    assign imem_en   = issue;
    assign imem_addr = pc_index(pc_q, START_PC);
    assign out_valid = (occ != '0);
    assign fault     = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fault_q    <= 1'b0;
            pc_q       <= START_PC;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            case (state_q)
                RUN: begin
                    if (redirect_bad || (issue_opp && !pc_legal(pc_q, START_PC, IM_WORDS))) begin
                        state_q <= HALT;
                        fault_q <= 1'b1;
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc_q <= pc_q;
    end

    fetch_buf #(
        .DEPTH  (BUF_DEPTH),
        .RST_PC (START_PC)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_pc_i    (inflight_pc_q),
        .push_instr_i (imem_rdata),
        .pop_i        (pop),
        .flush_i      (redirect_ok),
        .count_o      (occ),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; memory word at index i reads back as 0x1000+i.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_en;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem_en ? (32'h1000 + {21'b0, imem_addr}) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change at edge+2, outputs are sampled at edge+3.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic tick_s();
        tick();
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = rdy;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int n_iss;

        // Reset values, then streaming fetch with decode always ready.
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_en", imem_en, 1'b0);
        check("rst_addr", imem_addr, 11'd0);
        check("rst_pc", out_pc, 32'h3000);
        check("rst_instr", out_instr, 32'h0);
        reset = 1'b0;
        #1;
        check("c0_en", imem_en, 1'b1);
        check("c0_addr", imem_addr, 11'd0);
        check("c0_valid", out_valid, 1'b0);
        for (int k = 1; k < 12; k++) begin
            tick_s();
            check("str_en", imem_en, 1'b1);
            check("str_addr", imem_addr, 11'(k));
            if (k == 1) check("str_valid1", out_valid, 1'b0);
            if (k >= 2) begin
                check("str_valid", out_valid, 1'b1);
                check("str_pc", out_pc, 32'h3000 + 32'(4 * (k - 2)));
                check("str_instr", out_instr, 32'h1000 + 32'(k - 2));
            end
        end

        // Reset in the middle of the stream.
        tick();
        reset = 1'b1;
        #1;
        check("mrst_en", imem_en, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_fault", fault, 1'b0);
        check("mrst_addr", imem_addr, 11'd0);
        check("mrst_en0", imem_en, 1'b1);
        tick_s();
        check("mrst_valid1", out_valid, 1'b0);
        tick_s();
        check("mrst_pc2", out_pc, 32'h3000);
        check("mrst_instr2", out_instr, 32'h1000);

        // Backpressure: exactly three issues, then ordered drain and resumed fetch.
        do_reset(1'b0);
        n_iss = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick_s();
            if (imem_en) n_iss++;
        end
        check("bp_issues", 32'(n_iss), 32'd3);
        check("bp_en9", imem_en, 1'b0);
        check("bp_head", out_pc, 32'h3000);
        tick();
        out_ready = 1'b1;
        #1;
        check("bp_c10_pc", out_pc, 32'h3000);
        check("bp_c10_en", imem_en, 1'b0);
        tick_s();
        check("bp_c11_pc", out_pc, 32'h3004);
        check("bp_c11_en", imem_en, 1'b1);
        check("bp_c11_addr", imem_addr, 11'd3);
        tick_s();
        check("bp_c12_pc", out_pc, 32'h3008);
        tick_s();
        check("bp_c13_pc", out_pc, 32'h300C);
        check("bp_c13_instr", out_instr, 32'h1003);
        tick_s();
        check("bp_c14_pc", out_pc, 32'h3010);

        // Redirect with two entries buffered and one read in flight.
        do_reset(1'b0);
        tick_s();
        tick_s();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        #1;
        check("rd_t_en", imem_en, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rd_t1_valid", out_valid, 1'b0);
        check("rd_t1_en", imem_en, 1'b1);
        check("rd_t1_addr", imem_addr, 11'h040);
        tick_s();
        check("rd_t2_valid", out_valid, 1'b0);
        tick();
        out_ready = 1'b1;
        #1;
        check("rd_t3_valid", out_valid, 1'b1);
        check("rd_t3_pc", out_pc, 32'h3100);
        check("rd_t3_instr", out_instr, 32'h1040);
        tick_s();
        check("rd_t4_pc", out_pc, 32'h3104);
        check("rd_t4_instr", out_instr, 32'h1041);

        // Misaligned redirect: trap, drain what is buffered, fault stays sticky.
        do_reset(1'b0);
        tick_s();
        tick_s();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3002;
        #1;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        check("mis_fault", fault, 1'b1);
        check("mis_en", imem_en, 1'b0);
        check("mis_pc0", out_pc, 32'h3000);
        check("mis_instr0", out_instr, 32'h1000);
        tick_s();
        check("mis_pc1", out_pc, 32'h3004);
        tick_s();
        tick_s();
        tick_s();
        check("mis_empty", out_valid, 1'b0);
        check("mis_en_late", imem_en, 1'b0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("mis_sticky", fault, 1'b1);
        check("mis_sticky_en", imem_en, 1'b0);

        // Out-of-range redirect straight after reset.
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h5000;
        #1;
        check("oor_t_en", imem_en, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("oor_fault", fault, 1'b1);
        check("oor_en", imem_en, 1'b0);
        tick_s();
        check("oor_valid", out_valid, 1'b0);

        // Sequential fetch across the top of memory.
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4FF4;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("top_c1_addr", imem_addr, 11'h7FD);
        check("top_c1_en", imem_en, 1'b1);
        tick_s();
        tick_s();
        check("top_c3_en", imem_en, 1'b1);
        check("top_c3_addr", imem_addr, 11'h7FF);
        check("top_c3_pc", out_pc, 32'h4FF4);
        tick_s();
        check("top_c4_en", imem_en, 1'b0);
        check("top_c4_pc", out_pc, 32'h4FF8);
        check("top_c4_fault", fault, 1'b0);
        tick_s();
        check("top_c5_fault", fault, 1'b1);
        check("top_c5_pc", out_pc, 32'h4FFC);
        check("top_c5_instr", out_instr, 32'h17FF);
        tick_s();
        check("top_c6_valid", out_valid, 1'b0);

        // Reset clears the sticky fault.
        do_reset(1'b1);
        check("clr_fault", fault, 1'b0);
        check("clr_en", imem_en, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
